// File: rtl/mp_pkg.sv
// Shared constants for the multi-precision modular reducer.
// Limb width and FSM state encoding.
package mp_pkg;

  localparam int LIMB_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB_LO = 2'd1,
    SUB_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mp_sub64.sv
// One-limb subtractor: diff = a - b - borrow_in.
// Ports: a, b, borrow_in in; diff, borrow_out out.
module mp_sub64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] w_ext;

  // The extra top bit wraps to 1 exactly when a borrow is needed.
  assign w_ext = {1'b0, a} - {1'b0, b} - (W+1)'(borrow_in);

  assign diff       = w_ext[W-1:0];
  assign borrow_out = w_ext[W];

endmodule

// File: rtl/mp_modreduce.sv
// Conditional subtract C mod M, one limb per cycle.
// Ports: clk, resetn, start, C, M in; R, done, busy out.
module mp_modreduce #(
  parameter int LIMB_W = mp_pkg::LIMB_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [2*LIMB_W:0] C,
  input  logic [2*LIMB_W-1:0] M,
  output logic [2*LIMB_W-1:0] R,
  output logic              done,
  output logic              busy
);

  import mp_pkg::*;

  state_t              r_state;
  logic [2*LIMB_W:0]   r_c;
  logic [2*LIMB_W-1:0] r_m;
  logic [LIMB_W-1:0]   r_lo;
  logic                r_bor;
  logic [2*LIMB_W-1:0] r_r;

  logic                w_hi;
  logic [LIMB_W-1:0]   w_a;
  logic [LIMB_W-1:0]   w_b;
  logic                w_bin;
  logic [LIMB_W-1:0]   w_diff;
  logic                w_bout;
  logic                w_take;

  // One shared subtractor: low limbs in SUB_LO, high limbs in SUB_HI.
  assign w_hi  = (r_state == SUB_HI);
  assign w_a   = w_hi ? r_c[2*LIMB_W-1:LIMB_W] : r_c[LIMB_W-1:0];
  assign w_b   = w_hi ? r_m[2*LIMB_W-1:LIMB_W] : r_m[LIMB_W-1:0];
  assign w_bin = w_hi & r_bor;

  mp_sub64 #(
    .W(LIMB_W)
  ) u_sub (
    .a         (w_a),
    .b         (w_b),
    .borrow_in (w_bin),
    .diff      (w_diff),
    .borrow_out(w_bout)
  );

  // Carry bit set means C >= 2^128 > M, so subtract regardless of b.
  assign w_take = r_c[2*LIMB_W] | ~w_bout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_m     <= '0;
      r_lo    <= '0;
      r_bor   <= 1'b0;
      r_r     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_c     <= C;
            r_m     <= M;
            r_state <= SUB_LO;
          end
        end
        SUB_LO: begin
          r_lo    <= w_diff;
          r_bor   <= w_bout;
          r_state <= SUB_HI;
        end
        SUB_HI: begin
          r_r     <= w_take ? {w_diff, r_lo}
                            : r_c[2*LIMB_W-1:0];
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign R    = r_r;
  assign done = (r_state == DONE);
  assign busy = (r_state != IDLE);

endmodule
